// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx.
// The master side supplies parallel words. The slave side is the transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         p;
    logic                     p_valid;
    logic                     p_ready;
    logic                     s;
    logic                     s_valid;
    logic                     frame;
    logic                     busy;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output p, p_valid,
        input  p_ready, s, s_valid, frame, busy, count
    );

    modport slave (
        input  p, p_valid,
        output p_ready, s, s_valid, frame, busy, count
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-to-serial transmitter with a DEPTH-word input FIFO.
// Words are shifted out MSB first. frame marks the MSB cycle, and consecutive words follow with no gap.
//
// state | meaning
// IDLE  | shifter empty, s/s_valid/frame held low
// SHIFT | a word is in the shifter, bit bc_q is currently on s
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic      clk,
    input logic      reset,
    piso_tx_if.slave tx
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sr_q;
    logic [BCW-1:0]   bc_q;
    logic             s_q, s_valid_q, frame_q;

    logic             fifo_empty, p_ready_w, last_bit, push, pop;
    logic [WIDTH-1:0] head;

    assign fifo_empty = (count_q == '0);
    assign p_ready_w  = (count_q != CW'(DEPTH));
    assign last_bit   = (bc_q == BCW'(WIDTH - 1));
    assign push       = tx.p_valid && p_ready_w;
    // Pop is decided from the registered count, so a word pushed into an empty FIFO waits one edge.
    assign pop        = !fifo_empty && ((state_q == IDLE) || last_bit);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= tx.p;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bc_q      <= '0;
            s_q       <= 1'b0;
            s_valid_q <= 1'b0;
            frame_q   <= 1'b0;
        end else if (pop) begin
            state_q   <= SHIFT;
            sr_q      <= head;
            bc_q      <= '0;
            s_q       <= head[WIDTH-1];
            s_valid_q <= 1'b1;
            frame_q   <= 1'b1;
        end else if (state_q == SHIFT && !last_bit) begin
            sr_q      <= {sr_q[WIDTH-2:0], 1'b0};
            bc_q      <= bc_q + 1'b1;
            s_q       <= sr_q[WIDTH-2];
            s_valid_q <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= IDLE;
            s_q       <= 1'b0;
            s_valid_q <= 1'b0;
            frame_q   <= 1'b0;
        end
    end

    assign tx.p_ready = p_ready_w;
    assign tx.s       = s_q;
    assign tx.s_valid = s_valid_q;
    assign tx.frame   = frame_q;
    assign tx.busy    = (state_q == SHIFT) || !fifo_empty;
    assign tx.count   = count_q;
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed scenarios and random traffic checked against a queue-based model.
// A loopback receiver rebuilds words from s and compares them with the accepted words, in order.
module tb_piso_tx;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W), .DEPTH(D)) bus ();
    piso_tx #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(rst_n), .tx(bus));

    int checks   = 0;
    int failures = 0;

    // Model: the FIFO contents, and the bits of the current word still to appear on s (front = on s now).
    logic [W-1:0] mq[$];
    bit           mcur[$];
    bit           mframe;
    logic [W-1:0] sent_q[$];
    logic [W-1:0] rx_sr;
    int           rx_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_sample();
        if (bus.s_valid === 1'b1) begin
            if (bus.frame === 1'b1) rx_n = 0;
            rx_sr = {rx_sr[W-2:0], bus.s};
            rx_n++;
            if (rx_n == W) begin
                if (sent_q.size() == 0) chk("rx_unexpected_word", 32'(rx_sr), 32'hFFFF_FFFF);
                else chk("rx_word", 32'(rx_sr), 32'(sent_q.pop_front()));
                rx_n = 0;
            end
        end
    endtask

    task automatic model_edge(output bit acc);
        bit do_pop, do_push;
        logic [W-1:0] w;
        acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            mcur.delete();
            mframe = 1'b0;
            return;
        end
        do_pop  = (mcur.size() <= 1) && (mq.size() > 0);
        do_push = (bus.p_valid === 1'b1) && (mq.size() < D);
        mframe  = 1'b0;
        if (do_pop) begin
            w = mq.pop_front();
            mcur.delete();
            for (int i = W - 1; i >= 0; i--) mcur.push_back(w[i]);
            mframe = 1'b1;
        end else if (mcur.size() > 0) begin
            void'(mcur.pop_front());
        end
        if (do_push) begin
            mq.push_back(bus.p);
            acc = 1'b1;
        end
    endtask

    task automatic tick(output bit acc);
        if (rst_n) rx_sample();
        model_edge(acc);
        if (acc) sent_q.push_back(bus.p);
        if (!rst_n) begin
            sent_q.delete();
            rx_n  = 0;
            rx_sr = '0;
        end
        @(posedge clk);
        #1;
        chk("s_valid", 32'(bus.s_valid), 32'(mcur.size() > 0));
        chk("s",       32'(bus.s),       32'(mcur.size() > 0 ? mcur[0] : 1'b0));
        chk("frame",   32'(bus.frame),   32'(mframe));
        chk("count",   32'(bus.count),   32'(mq.size()));
        chk("p_ready", 32'(bus.p_ready), 32'(mq.size() != D));
        chk("busy",    32'(bus.busy),    32'((mcur.size() > 0) || (mq.size() > 0)));
    endtask

    task automatic idle(input int n);
        bit a;
        bus.p_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send(input logic [W-1:0] w);
        bit a;
        bus.p = w;
        bus.p_valid = 1'b1;
        tick(a);
        chk("send_accepted", 32'(a), 32'd1);
        bus.p_valid = 1'b0;
    endtask

    initial begin
        bit a;
        int nxt, guard;
        rx_n = 0;
        rx_sr = '0;
        mframe = 1'b0;
        bus.p = '0;
        bus.p_valid = 1'b0;
        rst_n = 1'b0;
        tick(a);
        tick(a);
        rst_n = 1'b1;
        chk("reset_p_ready", 32'(bus.p_ready), 32'd1);
        chk("reset_count", 32'(bus.count), 32'd0);

        // Single word: MSB one cycle after accept, the LSB 7 cycles later, then idle.
        send(8'hA5);
        tick(a);
        chk("a5_frame_msb", {30'd0, bus.frame, bus.s}, 32'd3);
        idle(10);
        chk("a5_done_busy", 32'(bus.busy), 32'd0);

        // Back-to-back words with no gap between them.
        send(8'h3C);
        send(8'hFF);
        idle(20);

        // Hold p_valid high with a rising sequence, and fill the FIFO until p_ready drops.
        nxt = 1;
        guard = 0;
        bus.p_valid = 1'b1;
        while (nxt <= 8 && guard < 200) begin
            bus.p = W'(nxt);
            tick(a);
            if (a) nxt++;
            guard++;
        end
        chk("stream_all_accepted", 32'(nxt), 32'd9);
        idle(40);
        chk("stream_drained_count", 32'(bus.count), 32'd0);

        // Reset in the middle of a word, then send a clean word.
        send(8'hF0);
        for (int i = 0; i < 3; i++) tick(a);
        bus.p = 8'h77;
        bus.p_valid = 1'b1;
        rst_n = 1'b0;
        tick(a);
        rst_n = 1'b1;
        bus.p_valid = 1'b0;
        chk("rst_mid_s_valid", 32'(bus.s_valid), 32'd0);
        chk("rst_mid_count", 32'(bus.count), 32'd0);
        send(8'h81);
        idle(12);

        // A word on p with p_valid low is ignored. Pushes while full are refused.
        bus.p = 8'hAA;
        idle(5);
        chk("novalid_count", 32'(bus.count), 32'd0);
        bus.p_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.p = W'(8'h10 + i);
            tick(a);
        end
        idle(60);

        // Loopback pair.
        send(8'h5A);
        send(8'hC3);
        idle(20);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus.p = W'($urandom);
            bus.p_valid = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick(a);
        end
        rst_n = 1'b1;
        idle(60);
        chk("all_words_received", 32'(sent_q.size()), 32'd0);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
